// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM state codes, funct3 access
// codes, opcode_info bit positions and the per-size byte-enable pattern.
package lsu_pkg;

  // 2-bit state codes, kept as plain constants so legacy code can still use them
  localparam logic [1:0] LSU_ST_IDLE = 2'd0;
  localparam logic [1:0] LSU_ST_REQ  = 2'd1;
  localparam logic [1:0] LSU_ST_RSP  = 2'd2;
  localparam logic [1:0] LSU_ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = LSU_ST_IDLE,
    ST_REQ  = LSU_ST_REQ,
    ST_RSP  = LSU_ST_RSP,
    ST_DONE = LSU_ST_DONE
  } lsu_state_e;

  // funct3 access size/sign encodings (stores use the low four)
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  // opcode_info bit indices
  localparam int unsigned OP_LOAD  = 0;
  localparam int unsigned OP_STORE = 1;

  // byte enables for an access of the given size at lane 0
  function automatic logic [7:0] size_strb(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath helper for the LSU: store lane shifting and strobe
// generation, load lane extraction with sign/zero extension, and the
// misalignment / illegal-funct3 checks.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [2:0]        off,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   ld_data,
  output logic              misalign,
  output logic              illegal
);

  logic [XLEN-1:0] sh;

  // lane shifts, size checks and load extension
  always_comb begin
    wdata = st_data << {off, 3'b000};
    wstrb = size_strb(funct3[1:0]) << off;
    sh    = ld_raw >> {off, 3'b000};

    case (funct3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      default: misalign = |off;
    endcase

    illegal = is_store ? funct3[2] : (funct3 == 3'b111);

    case (funct3)
      LSU_B:   ld_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      LSU_H:   ld_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      LSU_W:   ld_data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      LSU_BU:  ld_data = {{(XLEN-8){1'b0}}, sh[7:0]};
      LSU_HU:  ld_data = {{(XLEN-16){1'b0}}, sh[15:0]};
      LSU_WU:  ld_data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request/response bus transaction per LOAD/STORE,
// stalling the core while in flight. XLEN must be 64 (doubleword lanes).
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_load_i,
  input  logic              op_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   rs1_rdata_i,
  input  logic [XLEN-1:0]   rs2_rdata_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              lsu_illegal_o,
  output logic              lsu_fault_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_rdata_i,
  input  logic              mem_rsp_err_i
);

  lsu_state_e        state_q;
  logic [XLEN-1:0]   addr_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [XLEN-1:0]   rdata_q;
  logic              misalign_q;
  logic              illegal_q;
  logic              fault_q;

  logic [1:0]        op;
  logic [XLEN-1:0]   addr;
  logic              idle;
  logic              start;

  logic [2:0]        a_funct3;
  logic [2:0]        a_off;
  logic              a_store;
  logic [XLEN-1:0]   a_wdata;
  logic [STRB_W-1:0] a_wstrb;
  logic [XLEN-1:0]   a_ld_data;
  logic              a_misalign;
  logic              a_illegal;

  assign op = {op_store_i, op_load_i};

  // start decode; reset also masks start so every output is 0 under reset
  always_comb begin
    addr  = rs1_rdata_i + imm_i;
    idle  = (state_q == ST_IDLE);
    start = (op[OP_LOAD] | op[OP_STORE]) & idle & ~lsu_done_o & ~rst_i;
  end

  // the single aligner sees live inputs in IDLE and the latched access afterwards
  always_comb begin
    a_funct3 = idle ? funct3_i       : funct3_q;
    a_off    = idle ? addr[2:0]      : addr_q[2:0];
    a_store  = idle ? op[OP_STORE]   : we_q;
  end

  lsu_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W)
  ) u_align (
    .funct3   (a_funct3),
    .is_store (a_store),
    .off      (a_off),
    .st_data  (rs2_rdata_i),
    .ld_raw   (mem_rsp_rdata_i),
    .wdata    (a_wdata),
    .wstrb    (a_wstrb),
    .ld_data  (a_ld_data),
    .misalign (a_misalign),
    .illegal  (a_illegal)
  );

  // transaction FSM with latched request and captured result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q   <= addr;
            we_q     <= op[OP_STORE];
            funct3_q <= funct3_i;
            wdata_q  <= op[OP_STORE] ? a_wdata : '0;
            wstrb_q  <= op[OP_STORE] ? a_wstrb : '0;
            if (a_misalign | a_illegal) begin
              misalign_q <= a_misalign;
              illegal_q  <= a_illegal;
              fault_q    <= 1'b0;
              rdata_q    <= '0;
              state_q    <= ST_DONE;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) state_q <= ST_RSP;
        end
        ST_RSP: begin
          if (mem_rsp_valid_i) begin
            // stores return no data, so their result reads as 0
            rdata_q    <= (mem_rsp_err_i | we_q) ? '0 : a_ld_data;
            fault_q    <= mem_rsp_err_i;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            state_q    <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // status and bus outputs; results are visible only in the DONE cycle
  always_comb begin
    lsu_done_o      = (state_q == ST_DONE);
    lsu_busy_o      = start | (state_q == ST_REQ) | (state_q == ST_RSP);
    lsu_rdata_o     = lsu_done_o ? rdata_q : '0;
    lsu_misalign_o  = lsu_done_o & misalign_q;
    lsu_illegal_o   = lsu_done_o & illegal_q;
    lsu_fault_o     = lsu_done_o & fault_q;
    mem_req_valid_o = (state_q == ST_REQ);
    mem_addr_o      = {addr_q[XLEN-1:3], 3'b000};
    mem_we_o        = we_q;
    mem_wdata_o     = wdata_q;
    mem_wstrb_o     = wstrb_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// checked cycle by cycle against a byte-level reference model.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        op_load_i, op_store_i;
  logic [2:0]  funct3_i;
  logic [63:0] rs1_rdata_i, rs2_rdata_i, imm_i;
  logic        lsu_busy_o, lsu_done_o;
  logic [63:0] lsu_rdata_o;
  logic        lsu_misalign_o, lsu_illegal_o, lsu_fault_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;
  logic        mem_rsp_err_i;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  lsu #(.XLEN(64), .STRB_W(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .op_load_i       (op_load_i),
    .op_store_i      (op_store_i),
    .funct3_i        (funct3_i),
    .rs1_rdata_i     (rs1_rdata_i),
    .rs2_rdata_i     (rs2_rdata_i),
    .imm_i           (imm_i),
    .lsu_busy_o      (lsu_busy_o),
    .lsu_done_o      (lsu_done_o),
    .lsu_rdata_o     (lsu_rdata_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .lsu_illegal_o   (lsu_illegal_o),
    .lsu_fault_o     (lsu_fault_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_we_o        (mem_we_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wstrb_o     (mem_wstrb_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .mem_rsp_err_i   (mem_rsp_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        misalign;
    logic        illegal;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
  } exp_t;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // reference: access is nbytes wide at byte offset off within the doubleword
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] rs2, input logic [63:0] bus, input logic err);
    exp_t        e;
    int unsigned nbytes;
    int unsigned off;
    logic [63:0] mask;
    logic [63:0] v;
    nbytes     = 1 << f3[1:0];
    off        = addr % 8;
    e.illegal  = st ? (f3 >= 3'd4) : (f3 == 3'd7);
    e.misalign = (off % nbytes) != 0;
    e.wdata    = st ? (rs2 << (8 * off)) : 64'd0;
    e.wstrb    = st ? 8'(((32'd1 << nbytes) - 32'd1) << off) : 8'd0;
    mask       = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v          = (bus >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
    e.rdata    = (st || err || e.misalign || e.illegal) ? 64'd0 : v;
    return e;
  endfunction

  task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                         input logic [63:0] rs1, input logic [63:0] imm, input logic [63:0] rs2,
                         input logic [63:0] bus, input logic err,
                         input int unsigned rwait, input int unsigned swait);
    exp_t        e;
    logic [63:0] addr;
    addr = rs1 + imm;
    e = model(st, f3, addr, rs2, bus, err);
    op_load_i   = ~st;
    op_store_i  = st;
    funct3_i    = f3;
    rs1_rdata_i = rs1;
    rs2_rdata_i = rs2;
    imm_i       = imm;
    #1;
    check_val({tag, ".start_busy"}, lsu_busy_o, 1);
    check_val({tag, ".start_req"}, mem_req_valid_o, 0);
    check_val({tag, ".start_done"}, lsu_done_o, 0);
    tick();
    if (e.misalign || e.illegal) begin
      check_val({tag, ".err_done"}, lsu_done_o, 1);
      check_val({tag, ".err_misalign"}, lsu_misalign_o, e.misalign);
      check_val({tag, ".err_illegal"}, lsu_illegal_o, e.illegal);
      check_val({tag, ".err_fault"}, lsu_fault_o, 0);
      check_val({tag, ".err_rdata"}, lsu_rdata_o, 0);
      check_val({tag, ".err_req"}, mem_req_valid_o, 0);
      check_val({tag, ".err_busy"}, lsu_busy_o, 0);
    end else begin
      for (int unsigned w = 0; w <= rwait; w++) begin
        check_val({tag, ".req_valid"}, mem_req_valid_o, 1);
        check_val({tag, ".req_busy"}, lsu_busy_o, 1);
        check_val({tag, ".req_done"}, lsu_done_o, 0);
        check_val({tag, ".req_addr"}, mem_addr_o, addr & ~64'd7);
        check_val({tag, ".req_we"}, mem_we_o, st);
        check_val({tag, ".req_wdata"}, mem_wdata_o, e.wdata);
        check_val({tag, ".req_wstrb"}, mem_wstrb_o, e.wstrb);
        mem_req_ready_i = (w == rwait);
        // stray responses while the request is pending must be ignored
        mem_rsp_valid_i = (w == rwait) ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rsp_rdata_i = rnd64();
        mem_rsp_err_i   = 1'($urandom_range(0, 1));
        tick();
      end
      mem_req_ready_i = 1'b0;
      for (int unsigned w = 0; w <= swait; w++) begin
        check_val({tag, ".rsp_req"}, mem_req_valid_o, 0);
        check_val({tag, ".rsp_busy"}, lsu_busy_o, 1);
        check_val({tag, ".rsp_done"}, lsu_done_o, 0);
        mem_rsp_valid_i = (w == swait);
        mem_rsp_rdata_i = (w == swait) ? bus : rnd64();
        mem_rsp_err_i   = (w == swait) ? err : 1'($urandom_range(0, 1));
        tick();
      end
      mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i   = 1'b0;
      check_val({tag, ".done"}, lsu_done_o, 1);
      check_val({tag, ".rdata"}, lsu_rdata_o, e.rdata);
      check_val({tag, ".fault"}, lsu_fault_o, err);
      check_val({tag, ".misalign"}, lsu_misalign_o, 0);
      check_val({tag, ".illegal"}, lsu_illegal_o, 0);
      check_val({tag, ".done_busy"}, lsu_busy_o, 0);
      check_val({tag, ".done_req"}, mem_req_valid_o, 0);
    end
    op_load_i  = 1'b0;
    op_store_i = 1'b0;
    tick();
    check_val({tag, ".after_done"}, lsu_done_o, 0);
    check_val({tag, ".after_rdata"}, lsu_rdata_o, 0);
    check_val({tag, ".after_busy"}, lsu_busy_o, 0);
  endtask

  initial begin
    logic [11:0] i12;
    logic [63:0] rs1, imm;
    rst_i           = 1'b1;
    op_load_i       = 1'b0;
    op_store_i      = 1'b0;
    funct3_i        = 3'd0;
    rs1_rdata_i     = '0;
    rs2_rdata_i     = '0;
    imm_i           = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_rdata_i = '0;
    mem_rsp_err_i   = 1'b0;
    repeat (2) tick();
    check_val("rst.busy", lsu_busy_o, 0);
    check_val("rst.done", lsu_done_o, 0);
    check_val("rst.rdata", lsu_rdata_o, 0);
    check_val("rst.flags", {lsu_misalign_o, lsu_illegal_o, lsu_fault_o}, 0);
    check_val("rst.req", mem_req_valid_o, 0);
    check_val("rst.addr", mem_addr_o, 0);
    check_val("rst.we", mem_we_o, 0);
    check_val("rst.wdata", mem_wdata_o, 0);
    check_val("rst.wstrb", mem_wstrb_o, 0);
    rst_i = 1'b0;
    tick();

    // directed scenarios
    run_txn("ld", 1'b0, 3'b011, 64'h1000, 64'd8, 64'd0, 64'h1122334455667788, 1'b0, 0, 0);
    run_txn("lb", 1'b0, 3'b000, 64'h2000, 64'd3, 64'd0, 64'h0000000080000000, 1'b0, 0, 0);
    run_txn("lbu", 1'b0, 3'b100, 64'h2000, 64'd3, 64'd0, 64'h0000000080000000, 1'b0, 0, 0);
    run_txn("sh", 1'b1, 3'b001, 64'h3000, 64'd6, 64'hABCD, rnd64(), 1'b0, 3, 1);
    run_txn("lw_mis", 1'b0, 3'b010, 64'h4000, 64'd2, 64'd0, 64'd0, 1'b0, 0, 0);
    run_txn("st_ill", 1'b1, 3'b100, 64'h4000, 64'd0, 64'h55, 64'd0, 1'b0, 0, 0);
    run_txn("ld_err", 1'b0, 3'b011, 64'h5000, 64'd0, 64'd0, 64'hDEADBEEFDEADBEEF, 1'b1, 0, 2);
    run_txn("ld_wrap", 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1, 0);

    // reset while the request is pending
    op_load_i   = 1'b1;
    funct3_i    = 3'b011;
    rs1_rdata_i = 64'h6000;
    imm_i       = 64'd0;
    tick();
    check_val("rstmid.req_before", mem_req_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("rstmid.req_dropped", mem_req_valid_o, 0);
    check_val("rstmid.busy", lsu_busy_o, 0);
    check_val("rstmid.done", lsu_done_o, 0);
    op_load_i = 1'b0;
    tick();
    rst_i           = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rsp_valid_i = 1'b0;
    check_val("rstmid.late_rsp_done", lsu_done_o, 0);
    check_val("rstmid.late_rsp_busy", lsu_busy_o, 0);
    check_val("rstmid.late_rsp_req", mem_req_valid_o, 0);
    run_txn("ld_after_rst", 1'b0, 3'b011, 64'h7000, 64'd0, 64'd0, 64'hCAFEF00D12345678, 1'b0, 0, 0);

    // randomized accesses
    for (int unsigned n = 0; n < 200; n++) begin
      i12 = 12'($urandom);
      imm = $urandom_range(0, 1) ? {{52{i12[11]}}, i12} : rnd64();
      rs1 = rnd64();
      if ($urandom_range(0, 1) == 1) rs1[2:0] = 3'(-imm[2:0]);
      run_txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rs1, imm, rnd64(),
              rnd64(), ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
